fact_param: RTL and testbench
=============================

Name: fact_param

Overview:
- Iterative factorial engine, parametrised successor to the fixed 4-bit/32-bit `fact` unit.
- Computes n! by repeated multiply-decrement under a go/done handshake.
- Detects result overflow for any configured width and exposes FSM state for debug.
- Sits as a standalone compute slave driven by a controller or testbench over the go/in/done/error interface.

Parameters:
- IN_W, 4, width of operand n (n range 0 .. 2^IN_W-1)
- OUT_W, 32, width of result and product register

Ports:
- clk, input, 1, system clock; all state updates on rising edge
- rst, input, 1, asynchronous active-high reset
- go, input, 1, start request (level); sampled only in IDLE
- in, input, IN_W, operand n; latched on the accepted start
- done, output, 1, result valid (level, held in DONE)
- error, output, 1, overflow flag (level, held in ERR)
- busy, output, 1, high while in CALC
- cs, output, 2, current FSM state code
- result, output, OUT_W, factorial result

Behaviour:
- Reset (rst=1, asynchronous) forces the following, regardless of state:
  - state=IDLE, done=0, error=0, busy=0, cs=0, result=0
  - internal prod=1, cnt=0
- State codes on cs: IDLE=0, CALC=1, DONE=2, ERR=3.
- IDLE:
  - If go=1 at the edge: latch cnt<=in, prod<=1, go to CALC.
  - Otherwise stay; result keeps its last value.
- CALC (busy=1):
  - If cnt<=1: result<=prod[OUT_W-1:0], go to DONE.
  - Else: form the full 2*OUT_W-bit product p=prod*cnt.
    - If p[2*OUT_W-1:OUT_W] != 0: go to ERR, result<=0.
    - Else prod<=p[OUT_W-1:0], cnt<=cnt-1, stay in CALC.
- Latency: CALC lasts max(n,1) cycles. done rises on the edge that ends the last CALC cycle.
  - n=3: CALC for 3 cycles, done high on the 4th cycle after the go-sampling edge.
- DONE: done=1, result stable. Stay while go=1; on go=0 return to IDLE (done drops the same edge).
- ERR: error=1, done=0, result=0. Stay while go=1; on go=0 return to IDLE.
- Handshake: exactly one computation per go assertion. The requester must drop go after done or error before the next start.
- Boundary conditions:
  - 0! = 1! = 1 (single CALC cycle).
  - in changes during CALC/DONE: ignored (operand latched).
  - go dropped mid-CALC: computation completes, then DONE/ERR exits to IDLE on the next edge since go=0.
  - rst mid-CALC: immediate abort to reset values; no done/error pulse.
  - Overflow check uses the full-width product, so the result is exact for every n whose factorial fits OUT_W bits and error is raised for every n that does not.
- Arithmetic: unsigned throughout; cnt is IN_W bits, zero-extended to OUT_W before the multiply.
- A multiplier of OUT_W x OUT_W is inferred; no other datapath width constraints apply.

Optional Feature:
- Macro: FACT_SATURATE_EN
- Defined:
  - On overflow, result<=all ones ({OUT_W{1'b1}}) and error=1 in ERR.
  - DONE/ERR exit rules are unchanged.
- Undefined: result=0 on overflow as specified above.

Test Plan:
- Default params, in=3, go held high → busy for 3 cycles, cs 0→1→2, done=1, result=6, error=0. Drop go → IDLE next edge.
- in=0 then in=1 (go pulsed each time, dropped after done) → result=1 for each, CALC exactly 1 cycle.
- Sweep in=2..12 → results 2, 6, 24, 120, 720, 5040, 40320, 362880, 3628800, 39916800, 479001600 with error=0. in=13 → error=1, done=0, result=0 (13! = 6227020800 exceeds 32 bits).
- IN_W=5, OUT_W=64: in=20 → result=2432902008176640000. in=21 → error=1.
- in=10, assert rst 4 cycles into CALC → all outputs reset immediately, no done. Restart with in=5 → result=120.
- FACT_SATURATE_EN defined, defaults, in=15 → error=1, result=32'hFFFFFFFF. in=12 afterwards → result=479001600.

Source files
------------

// File: rtl/fact_param_if.sv
// fact_param_if: start/operand/result bundle between a requester and the
// fact_param factorial engine.
//   master : requester side (drives go/in, observes status and result)
//   slave  : engine side
interface fact_param_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 32
);
  logic             go;
  logic [IN_W-1:0]  in;
  logic             done;
  logic             error;
  logic             busy;
  logic [1:0]       cs;
  logic [OUT_W-1:0] result;

  modport master (
    output go, in,
    input  done, error, busy, cs, result
  );

  modport slave (
    input  go, in,
    output done, error, busy, cs, result
  );
endinterface

// File: rtl/fact_param.sv
// fact_param: iterative factorial engine (n! by repeated multiply-decrement).
// A start is accepted in IDLE when go is high; the operand is latched then and
// later changes on bus.in are ignored.  Overflow is detected on the full
// 2*OUT_W-bit product, so every result that fits OUT_W bits is exact.
//
// Optional build macro FACT_SATURATE_EN: on overflow the result register is
// loaded with all ones instead of zero.  Exit rules are the same either way.
module fact_param #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  fact_param_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [IN_W-1:0]  CNT_ONE  = IN_W'(1'b1);
  localparam logic [OUT_W-1:0] PROD_ONE = OUT_W'(1'b1);
  localparam logic [OUT_W-1:0] RES_ZERO = {OUT_W{1'b0}};
`ifdef FACT_SATURATE_EN
  localparam logic [OUT_W-1:0] OVF_RESULT = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] OVF_RESULT = {OUT_W{1'b0}};
`endif

  state_t             state_r, state_next_s;
  logic [OUT_W-1:0]   prod_r, prod_next_s;
  logic [IN_W-1:0]    cnt_r, cnt_next_s;
  logic [OUT_W-1:0]   result_r, result_next_s;

  // Both factors are widened to 2*OUT_W so the upper half exposes overflow.
  logic [2*OUT_W-1:0] prod_wide_s;
  logic [2*OUT_W-1:0] cnt_wide_s;
  logic [2*OUT_W-1:0] full_s;
  logic               ovf_s;

  assign prod_wide_s = {{OUT_W{1'b0}}, prod_r};
  assign cnt_wide_s  = {{(2*OUT_W-IN_W){1'b0}}, cnt_r};
  assign full_s      = prod_wide_s * cnt_wide_s;
  assign ovf_s       = (full_s[2*OUT_W-1:OUT_W] != {OUT_W{1'b0}});

  // Status flags are pure decodes of the state register, so they change on
  // exactly the edge that changes state.
  assign bus.cs     = state_r;
  assign bus.busy   = (state_r == ST_CALC);
  assign bus.done   = (state_r == ST_DONE);
  assign bus.error  = (state_r == ST_ERR);
  assign bus.result = result_r;

  // State and datapath registers; rst aborts any computation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      prod_r   <= PROD_ONE;
      cnt_r    <= {IN_W{1'b0}};
      result_r <= RES_ZERO;
    end else begin
      state_r  <= state_next_s;
      prod_r   <= prod_next_s;
      cnt_r    <= cnt_next_s;
      result_r <= result_next_s;
    end
  end

  // Next-state and datapath update: one multiply-decrement step per CALC cycle.
  always_comb begin
    state_next_s  = state_r;
    prod_next_s   = prod_r;
    cnt_next_s    = cnt_r;
    result_next_s = result_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.go) begin
          cnt_next_s   = bus.in;
          prod_next_s  = PROD_ONE;
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        // cnt of 0 or 1 both finish with the running product (0! = 1! = 1).
        if (cnt_r <= CNT_ONE) begin
          result_next_s = prod_r;
          state_next_s  = ST_DONE;
        end else if (ovf_s) begin
          result_next_s = OVF_RESULT;
          state_next_s  = ST_ERR;
        end else begin
          prod_next_s  = full_s[OUT_W-1:0];
          cnt_next_s   = cnt_r - CNT_ONE;
          state_next_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (bus.go) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (bus.go) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fact_param.sv
// tb_fact_param: directed test of fact_param with default parameters and with
// IN_W=5 / OUT_W=64.  Expected values are hand-computed factorials.
// Build with FACT_SATURATE_EN to expect all-ones results on overflow.
module tb_fact_param;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

`ifdef FACT_SATURATE_EN
  localparam logic [31:0] OVF_A = 32'hFFFF_FFFF;
  localparam logic [63:0] OVF_B = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [31:0] OVF_A = 32'd0;
  localparam logic [63:0] OVF_B = 64'd0;
`endif

  fact_param_if #(.IN_W(4), .OUT_W(32)) bus_a ();
  fact_param_if #(.IN_W(5), .OUT_W(64)) bus_b ();

  fact_param #(.IN_W(4), .OUT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fact_param #(.IN_W(5), .OUT_W(64)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One full go/done handshake on the 32-bit engine. exp_calc=0 skips the
  // CALC-length check (used for overflow runs).
  task automatic run_a(input logic [3:0] n, input logic [31:0] exp_res,
                       input logic exp_err, input int exp_calc);
    int cycles;
    @(posedge clk); #1;
    check_val($sformatf("a_n%0d_idle_cs", n), 64'(bus_a.cs), 64'd0);
    bus_a.in = n;
    bus_a.go = 1'b1;
    @(posedge clk); #1;
    check_val($sformatf("a_n%0d_calc_cs", n), 64'(bus_a.cs), 64'd1);
    bus_a.in = ~n;  // operand is latched; this must have no effect
    cycles = 0;
    while (bus_a.busy && cycles < 64) begin
      cycles++;
      @(posedge clk); #1;
    end
    if (exp_calc > 0) check_val($sformatf("a_n%0d_calc_len", n), 64'(cycles), 64'(exp_calc));
    check_val($sformatf("a_n%0d_done", n),   64'(bus_a.done),  64'(!exp_err));
    check_val($sformatf("a_n%0d_error", n),  64'(bus_a.error), 64'(exp_err));
    check_val($sformatf("a_n%0d_result", n), 64'(bus_a.result), 64'(exp_res));
    check_val($sformatf("a_n%0d_end_cs", n), 64'(bus_a.cs), exp_err ? 64'd3 : 64'd2);
    @(posedge clk); #1;
    check_val($sformatf("a_n%0d_hold_cs", n), 64'(bus_a.cs), exp_err ? 64'd3 : 64'd2);
    bus_a.go = 1'b0;
    @(posedge clk); #1;
    check_val($sformatf("a_n%0d_exit_cs", n), 64'(bus_a.cs), 64'd0);
    check_val($sformatf("a_n%0d_exit_flags", n), 64'({bus_a.done, bus_a.error}), 64'd0);
    check_val($sformatf("a_n%0d_keep_result", n), 64'(bus_a.result), 64'(exp_res));
  endtask

  // Handshake on the 64-bit engine.
  task automatic run_b(input logic [4:0] n, input logic [63:0] exp_res, input logic exp_err);
    int cycles;
    @(posedge clk); #1;
    bus_b.in = n;
    bus_b.go = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (bus_b.busy && cycles < 64) begin
      cycles++;
      @(posedge clk); #1;
    end
    check_val($sformatf("b_n%0d_done", n),   64'(bus_b.done),  64'(!exp_err));
    check_val($sformatf("b_n%0d_error", n),  64'(bus_b.error), 64'(exp_err));
    check_val($sformatf("b_n%0d_result", n), bus_b.result, exp_res);
    bus_b.go = 1'b0;
    @(posedge clk); #1;
    check_val($sformatf("b_n%0d_exit_cs", n), 64'(bus_b.cs), 64'd0);
  endtask

  initial begin
    logic [31:0] fact_tbl [0:12];
    int cycles;
    fact_tbl = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040,
                 32'd40320, 32'd362880, 32'd3628800, 32'd39916800, 32'd479001600};
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus_a.go = 1'b0; bus_a.in = 4'd0;
    bus_b.go = 1'b0; bus_b.in = 5'd0;
    #2;
    check_val("rst_cs",     64'(bus_a.cs), 64'd0);
    check_val("rst_flags",  64'({bus_a.done, bus_a.error, bus_a.busy}), 64'd0);
    check_val("rst_result", 64'(bus_a.result), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic run with go held through DONE, then 0! and 1!.
    run_a(4'd3, 32'd6, 1'b0, 3);
    run_a(4'd0, 32'd1, 1'b0, 1);
    run_a(4'd1, 32'd1, 1'b0, 1);

    // Sweep 2..12, then first overflowing operand.
    for (int k = 2; k <= 12; k++) run_a(4'(k), fact_tbl[k], 1'b0, k);
    run_a(4'd13, OVF_A, 1'b1, 0);

    // go dropped one cycle into CALC: still completes, then leaves DONE at once.
    @(posedge clk); #1;
    bus_a.in = 4'd4; bus_a.go = 1'b1;
    @(posedge clk); #1;
    bus_a.go = 1'b0;
    cycles = 0;
    while (bus_a.busy && cycles < 64) begin
      cycles++;
      @(posedge clk); #1;
    end
    check_val("drop_done",   64'(bus_a.done), 64'd1);
    check_val("drop_result", 64'(bus_a.result), 64'd24);
    @(posedge clk); #1;
    check_val("drop_exit_cs", 64'(bus_a.cs), 64'd0);

    // Reset four cycles into CALC of 10!: immediate abort, no done.
    bus_a.in = 4'd10; bus_a.go = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    check_val("abort_pre_busy", 64'(bus_a.busy), 64'd1);
    rst = 1'b1;
    #1;
    check_val("abort_cs",     64'(bus_a.cs), 64'd0);
    check_val("abort_flags",  64'({bus_a.done, bus_a.error, bus_a.busy}), 64'd0);
    check_val("abort_result", 64'(bus_a.result), 64'd0);
    bus_a.go = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check_val("abort_no_done", 64'({bus_a.done, bus_a.error, bus_a.cs}), 64'd0);
    run_a(4'd5, 32'd120, 1'b0, 5);

    // Wide configuration.
    run_b(5'd20, 64'd2432902008176640000, 1'b0);
    run_b(5'd21, OVF_B, 1'b1);

    // Largest operand overflows; a fitting operand afterwards is exact again.
    run_a(4'd15, OVF_A, 1'b1, 0);
    run_a(4'd12, 32'd479001600, 1'b0, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

endmodule
